sns_history_buffer: RTL and testbench
=====================================

// Module: sns_history_buffer
// PURPOSE
//  Parametrised Shift-aNd-Save history buffer. Keeps the last DEPTH samples as a shift register, newest in slot 0.
//  Adds occupancy tracking, a freeze mode, a synchronous clear, a running sum, and an indexed registered read port.
//  Sits beside the interrupt/counter core and records event values or timestamps for CPU readback.
// PARAMETERS
//  DATA_WIDTH  32  width of each stored sample
//  DEPTH       10  number of history slots (>=2)
//  IDX_W       $clog2(DEPTH)  width of the read index
//  CNT_W       $clog2(DEPTH+1)  width of the occupancy count
//  DROP_W      16  width of the dropped-push counter
// PORTS
//  clk         in   1                  single clock, rising edge
//  reset       in   1                  synchronous, active-high reset
//  clear       in   1                  synchronous flush of contents, count and sum (drop_cnt kept)
//  freeze      in   1                  when 1, pushes are discarded and contents are held
//  push_en     in   1                  push request; push_data is sampled this cycle
//  push_data   in   DATA_WIDTH         new sample
//  rd_en       in   1                  read request
//  rd_idx      in   IDX_W              slot to read; 0 = newest
//  rd_data     out  DATA_WIDTH         read result, 1-cycle latency
//  rd_valid    out  1                  1-cycle pulse, one cycle after rd_en
//  rd_err      out  1                  1 with rd_valid when rd_idx >= count
//  count       out  CNT_W              number of valid entries, 0..DEPTH
//  full        out  1                  count == DEPTH
//  empty       out  1                  count == 0
//  sum         out  DATA_WIDTH+CNT_W   sum of all valid entries, registered
//  drop_cnt    out  DROP_W             pushes discarded while frozen; saturates at all-ones
// BEHAVIOUR
//  - Reset: all slots, count, sum, drop_cnt, rd_data, rd_valid and rd_err go to 0. empty=1, full=0.
//  - Priority, highest first: reset > clear > freeze > push. Reads are independent of all of these.
//  - Push (push_en & !freeze & !clear):
//      slot[i] <= slot[i-1] for i = DEPTH-1..1, and slot[0] <= push_data.
//      count <= min(count+1, DEPTH).
//      sum <= sum + push_data - slot[DEPTH-1].
//    Invalid slots always hold 0, so this sum update is exact both before and after the buffer is full.
//  - Full: a push still shifts; the oldest entry is evicted, count stays DEPTH, and no error is raised.
//  - Freeze: while freeze=1, push_en=1 leaves slots, count and sum unchanged; drop_cnt increments and saturates.
//  - Clear: zeroes all slots, count and sum in one cycle. A push in the same cycle is lost and is NOT counted as dropped.
//  - Read: on rd_en, the next cycle gives rd_valid=1 and rd_data = slot[rd_idx], using contents from BEFORE any same-cycle push or clear.
//    If rd_idx >= count (pre-update), or rd_idx >= DEPTH: rd_data=0 and rd_err=1.
//    Back-to-back reads are allowed every cycle; there is no backpressure.
//  - count, full, empty and sum are registered and reflect the state after the last clock edge.
//  - Reset or clear mid-read: a read already issued still completes next cycle with pre-clear data. Reset kills rd_valid.
//  - Sum width DATA_WIDTH+CNT_W cannot overflow: DEPTH*(2^DATA_WIDTH-1) fits. Arithmetic is unsigned.
// STRUCTURE
//  - Package sns_pkg: clog2 helper, default DATA_WIDTH/DEPTH localparams, sum-width expression.
//  - Sub-module sns_hist_rd_port: registered index mux and bounds check (rd_idx vs count) producing rd_data/rd_valid/rd_err.
//  - Top level holds the slot array, count/sum/drop_cnt registers and the priority logic.
// TESTING
//  1. Reset, then push 1,2,3 -> count=3, empty=0, sum=6; read idx0 -> rd_data=3 next cycle; idx2 -> 1; idx3 -> rd_err=1, rd_data=0.
//  2. DEPTH=10, push 1..12 -> count=10, full=1, sum=75 (3..12); idx9 reads 3, idx0 reads 12.
//  3. freeze=1 with 5 pushes -> contents/count/sum unchanged, drop_cnt=5; release freeze, push 7 -> slot0=7.
//  4. clear with push_en in the same cycle -> count=0, sum=0, empty=1, drop_cnt unchanged; the push data is absent.
//  5. rd_en idx0 in the same cycle as push 9 after [4] -> rd_data=4 (pre-push); the next read of idx0 returns 9.
//  6. reset asserted mid-stream after rd_en -> rd_valid=0 next cycle, all outputs 0; drop_cnt saturation checked with DROP_W=2 (stays 3).

Source files
------------

// File: rtl/sns_pkg.sv
// Shared definitions for the shift-and-save history buffer: default sizes,
// width helpers and the per-cycle update operation.
package sns_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 10;
   localparam int DEF_DROP_W     = 16;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Wide enough for DEPTH samples of all-ones without overflow.
   function automatic int sum_width(input int data_width, input int depth);
      return data_width + clog2(depth + 1);
   endfunction

   typedef enum logic [1:0] {
      OP_HOLD,
      OP_CLEAR,
      OP_DROP,
      OP_PUSH
   } sns_op_e;

endpackage

// File: rtl/sns_hist_rd_port.sv
// Registered read port of the history buffer: selects one slot by index and
// flags reads of slots that hold no valid sample.
module sns_hist_rd_port
   import sns_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int IDX_W      = clog2(DEPTH),
   parameter int CNT_W      = clog2(DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             rd_en,
   input  logic [IDX_W-1:0]                 rd_idx,
   input  logic [DEPTH-1:0][DATA_WIDTH-1:0] slots,
   input  logic [CNT_W-1:0]                 count,
   output logic [DATA_WIDTH-1:0]            rd_data,
   output logic                             rd_valid,
   output logic                             rd_err
);

   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_err_q, rd_err_d;
   logic                  in_range;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through the block can infer a latch.
      in_range   = (32'(rd_idx) < 32'(count)) && (32'(rd_idx) < 32'(DEPTH));
      rd_valid_d = rd_en;
      rd_err_d   = 1'b0;
      rd_data_d  = rd_data_q;
      if (rd_en) begin
         if (in_range) begin
            rd_data_d = slots[rd_idx];
         end else begin
            rd_data_d = '0;
            rd_err_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;

endmodule

// File: rtl/sns_history_buffer.sv
// Shift-and-save history of the last DEPTH samples (newest in slot 0) with
// occupancy, freeze, clear, running sum, drop counter and an indexed read port.
module sns_history_buffer
   import sns_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int IDX_W      = clog2(DEPTH),
   parameter int CNT_W      = clog2(DEPTH + 1),
   parameter int DROP_W     = DEF_DROP_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        freeze,
   input  logic                        push_en,
   input  logic [DATA_WIDTH-1:0]       push_data,
   input  logic                        rd_en,
   input  logic [IDX_W-1:0]            rd_idx,
   output logic [DATA_WIDTH-1:0]       rd_data,
   output logic                        rd_valid,
   output logic                        rd_err,
   output logic [CNT_W-1:0]            count,
   output logic                        full,
   output logic                        empty,
   output logic [DATA_WIDTH+CNT_W-1:0] sum,
   output logic [DROP_W-1:0]           drop_cnt
);

   localparam int SUM_W = DATA_WIDTH + CNT_W;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] slot_q, slot_d;
   logic [CNT_W-1:0]                 count_q, count_d;
   logic [SUM_W-1:0]                 sum_q, sum_d;
   logic [DROP_W-1:0]                drop_q, drop_d;
   sns_op_e                          op;

   always_comb begin
      if (clear)        op = OP_CLEAR;
      else if (freeze)  op = push_en ? OP_DROP : OP_HOLD;
      else if (push_en) op = OP_PUSH;
      else              op = OP_HOLD;
   end

   always_comb begin
      slot_d  = slot_q;
      count_d = count_q;
      sum_d   = sum_q;
      drop_d  = drop_q;
      unique case (op)
         OP_CLEAR: begin
            slot_d  = '0;
            count_d = '0;
            sum_d   = '0;
         end
         OP_DROP: begin
            if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
         end
         OP_PUSH: begin
            for (int i = DEPTH - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
            slot_d[0] = push_data;
            if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
            // Unused slots hold 0, so subtracting the evicted slot is exact at any fill level.
            sum_d = sum_q + SUM_W'(push_data) - SUM_W'(slot_q[DEPTH-1]);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the slot array is reset deliberately: empty slots must read as 0 for the running sum to stay exact.
         slot_q  <= '0;
         count_q <= '0;
         sum_q   <= '0;
         drop_q  <= '0;
      end else begin
         slot_q  <= slot_d;
         count_q <= count_d;
         sum_q   <= sum_d;
         drop_q  <= drop_d;
      end
   end

   // Reads see pre-edge contents, independent of any same-cycle push or clear.
   sns_hist_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_W      (IDX_W),
      .CNT_W      (CNT_W)
   ) u_rd_port (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en),
      .rd_idx   (rd_idx),
      .slots    (slot_q),
      .count    (count_q),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .rd_err   (rd_err)
   );

   assign count    = count_q;
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign sum      = sum_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sns_history_buffer.sv
// Bench for sns_history_buffer: directed scenarios plus randomized traffic
// checked against a queue-based model of the history.
module tb_sns_history_buffer;
   import sns_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 10;
   localparam int IDX_W = clog2(DEPTH);
   localparam int CNT_W = clog2(DEPTH + 1);
   localparam int SUM_W = sum_width(DW, DEPTH);

   logic             clk = 1'b0;
   logic             reset, clear, freeze, push_en, rd_en;
   logic [DW-1:0]    push_data;
   logic [IDX_W-1:0] rd_idx;

   logic [DW-1:0]    rd_data, s_rd_data;
   logic             rd_valid, rd_err, full, empty;
   logic             s_rd_valid, s_rd_err, s_full, s_empty;
   logic [CNT_W-1:0] count, s_count;
   logic [SUM_W-1:0] sum, s_sum;
   logic [15:0]      drop_cnt;
   logic [1:0]       s_drop_cnt;

   int checks = 0;
   int errors = 0;

   // Model: newest sample at the front of the queue.
   logic [DW-1:0] mq[$];
   int unsigned   m_drop;
   logic          exp_valid, exp_err;
   logic [DW-1:0] exp_data;

   always #5 clk = ~clk;

   sns_history_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W), .DROP_W(16)) dut (
      .clk(clk), .reset(reset), .clear(clear), .freeze(freeze), .push_en(push_en),
      .push_data(push_data), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data),
      .rd_valid(rd_valid), .rd_err(rd_err), .count(count), .full(full), .empty(empty),
      .sum(sum), .drop_cnt(drop_cnt)
   );

   sns_history_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W), .DROP_W(2)) dut_sat (
      .clk(clk), .reset(reset), .clear(clear), .freeze(freeze), .push_en(push_en),
      .push_data(push_data), .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(s_rd_data),
      .rd_valid(s_rd_valid), .rd_err(s_rd_err), .count(s_count), .full(s_full), .empty(s_empty),
      .sum(s_sum), .drop_cnt(s_drop_cnt)
   );

   function automatic logic [SUM_W-1:0] model_sum();
      logic [SUM_W-1:0] s;
      s = '0;
      foreach (mq[i]) s += SUM_W'(mq[i]);
      return s;
   endfunction

   function automatic logic [1:0] model_drop_sat();
      return (m_drop > 3) ? 2'd3 : 2'(m_drop);
   endfunction

   // Called at a falling edge; drives one cycle, advances the model, returns at the next falling edge.
   task automatic do_cycle(input logic r, input logic c, input logic f, input logic p,
                           input logic [DW-1:0] d, input logic re, input logic [IDX_W-1:0] ri);
      reset = r; clear = c; freeze = f; push_en = p; push_data = d; rd_en = re; rd_idx = ri;
      @(posedge clk);
      if (r) begin
         exp_valid = 1'b0; exp_err = 1'b0; exp_data = '0;
         mq.delete();
         m_drop = 0;
      end else begin
         exp_valid = re;
         exp_err   = 1'b0;
         if (re) begin
            if (int'(ri) < mq.size()) exp_data = mq[ri];
            else begin exp_data = '0; exp_err = 1'b1; end
         end
         if (c) mq.delete();
         else if (f) begin
            if (p && m_drop < 65535) m_drop++;
         end else if (p) begin
            mq.push_front(d);
            if (mq.size() > DEPTH) void'(mq.pop_back());
         end
      end
      @(negedge clk);
      reset = 0; clear = 0; freeze = 0; push_en = 0; push_data = '0; rd_en = 0; rd_idx = '0;
   endtask

   task automatic test_reset();
      do_cycle(1, 0, 0, 0, '0, 0, '0);
      do_cycle(1, 0, 0, 0, '0, 0, '0);
      checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); end
      checks++; if (sum !== '0 || drop_cnt !== '0) begin errors++; $display("FAIL reset_sum_drop got sum=%0d drop=%0d want 0 0", sum, drop_cnt); end
      checks++; if ({rd_valid, rd_err} !== 2'b00 || rd_data !== '0) begin errors++; $display("FAIL reset_rd got v=%b e=%b d=%0d want 0 0 0", rd_valid, rd_err, rd_data); end
   endtask

   task automatic test_basic();
      do_cycle(1, 0, 0, 0, '0, 0, '0);
      for (int i = 1; i <= 3; i++) do_cycle(0, 0, 0, 1, DW'(i), 0, '0);
      checks++; if (count !== 4'd3 || empty !== 1'b0) begin errors++; $display("FAIL basic_count got %0d empty=%b want 3 0", count, empty); end
      checks++; if (sum !== SUM_W'(6)) begin errors++; $display("FAIL basic_sum got %0d want 6", sum); end
      do_cycle(0, 0, 0, 0, '0, 1, 4'd0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd3 || rd_err !== 1'b0) begin errors++; $display("FAIL basic_rd0 got v=%b d=%0d e=%b want 1 3 0", rd_valid, rd_data, rd_err); end
      do_cycle(0, 0, 0, 0, '0, 1, 4'd2);
      checks++; if (rd_data !== 32'd1 || rd_err !== 1'b0) begin errors++; $display("FAIL basic_rd2 got d=%0d e=%b want 1 0", rd_data, rd_err); end
      do_cycle(0, 0, 0, 0, '0, 1, 4'd3);
      checks++; if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_data !== '0) begin errors++; $display("FAIL basic_rd3_err got v=%b e=%b d=%0d want 1 1 0", rd_valid, rd_err, rd_data); end
      do_cycle(0, 0, 0, 0, '0, 0, '0);
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b want 0", rd_valid); end
   endtask

   task automatic test_fill();
      do_cycle(1, 0, 0, 0, '0, 0, '0);
      for (int i = 1; i <= 12; i++) do_cycle(0, 0, 0, 1, DW'(i), 0, '0);
      checks++; if (count !== 4'd10 || full !== 1'b1) begin errors++; $display("FAIL fill_count got %0d full=%b want 10 1", count, full); end
      checks++; if (sum !== SUM_W'(75)) begin errors++; $display("FAIL fill_sum got %0d want 75", sum); end
      do_cycle(0, 0, 0, 0, '0, 1, 4'd9);
      checks++; if (rd_data !== 32'd3 || rd_err !== 1'b0) begin errors++; $display("FAIL fill_rd9 got d=%0d e=%b want 3 0", rd_data, rd_err); end
      do_cycle(0, 0, 0, 0, '0, 1, 4'd0);
      checks++; if (rd_data !== 32'd12) begin errors++; $display("FAIL fill_rd0 got %0d want 12", rd_data); end
      do_cycle(0, 0, 0, 0, '0, 1, 4'd12);
      checks++; if (rd_err !== 1'b1 || rd_data !== '0) begin errors++; $display("FAIL fill_rd_oob got e=%b d=%0d want 1 0", rd_err, rd_data); end
   endtask

   task automatic test_freeze();
      for (int i = 0; i < 5; i++) do_cycle(0, 0, 1, 1, DW'(100 + i), 0, '0);
      checks++; if (count !== 4'd10 || sum !== SUM_W'(75)) begin errors++; $display("FAIL freeze_hold got count=%0d sum=%0d want 10 75", count, sum); end
      checks++; if (drop_cnt !== 16'd5) begin errors++; $display("FAIL freeze_drop got %0d want 5", drop_cnt); end
      checks++; if (s_drop_cnt !== 2'd3) begin errors++; $display("FAIL freeze_drop_sat got %0d want 3", s_drop_cnt); end
      do_cycle(0, 0, 1, 0, '0, 1, 4'd0);
      checks++; if (rd_data !== 32'd12) begin errors++; $display("FAIL freeze_slot0 got %0d want 12", rd_data); end
      do_cycle(0, 0, 0, 1, 32'd7, 0, '0);
      do_cycle(0, 0, 0, 0, '0, 1, 4'd0);
      checks++; if (rd_data !== 32'd7) begin errors++; $display("FAIL unfreeze_slot0 got %0d want 7", rd_data); end
      checks++; if (sum !== SUM_W'(79)) begin errors++; $display("FAIL unfreeze_sum got %0d want 79", sum); end
   endtask

   task automatic test_clear();
      do_cycle(0, 1, 0, 1, 32'd55, 0, '0);
      checks++; if (count !== '0 || sum !== '0 || empty !== 1'b1) begin errors++; $display("FAIL clear_state got count=%0d sum=%0d empty=%b want 0 0 1", count, sum, empty); end
      checks++; if (drop_cnt !== 16'd5) begin errors++; $display("FAIL clear_drop got %0d want 5", drop_cnt); end
      do_cycle(0, 1, 1, 1, 32'd56, 1, 4'd0);
      checks++; if (rd_err !== 1'b1 || rd_data !== '0) begin errors++; $display("FAIL clear_push_absent got e=%b d=%0d want 1 0", rd_err, rd_data); end
      checks++; if (drop_cnt !== 16'd5) begin errors++; $display("FAIL clear_freeze_drop got %0d want 5", drop_cnt); end
   endtask

   task automatic test_back_to_back();
      do_cycle(0, 0, 0, 1, 32'd4, 0, '0);
      do_cycle(0, 0, 0, 1, 32'd9, 1, 4'd0);
      checks++; if (rd_data !== 32'd4 || rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_prepush got d=%0d v=%b want 4 1", rd_data, rd_valid); end
      do_cycle(0, 0, 0, 0, '0, 1, 4'd0);
      checks++; if (rd_data !== 32'd9 || rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_postpush got d=%0d v=%b want 9 1", rd_data, rd_valid); end
      checks++; if (count !== 4'd2 || sum !== SUM_W'(13)) begin errors++; $display("FAIL b2b_state got count=%0d sum=%0d want 2 13", count, sum); end
   endtask

   task automatic test_reset_mid();
      do_cycle(0, 0, 0, 1, 32'd8, 0, '0);
      do_cycle(0, 1, 0, 0, '0, 1, 4'd0);
      checks++; if (rd_valid !== 1'b1 || rd_data !== 32'd8 || count !== '0) begin errors++; $display("FAIL clear_mid_read got v=%b d=%0d count=%0d want 1 8 0", rd_valid, rd_data, count); end
      for (int i = 1; i <= 5; i++) do_cycle(0, 0, 0, 1, DW'(i * 11), 0, '0);
      do_cycle(1, 0, 0, 0, '0, 1, 4'd0);
      checks++; if (rd_valid !== 1'b0 || rd_data !== '0 || rd_err !== 1'b0) begin errors++; $display("FAIL reset_mid_read got v=%b d=%0d e=%b want 0 0 0", rd_valid, rd_data, rd_err); end
      checks++; if (count !== '0 || sum !== '0 || drop_cnt !== '0 || empty !== 1'b1) begin errors++; $display("FAIL reset_mid_state got count=%0d sum=%0d drop=%0d empty=%b", count, sum, drop_cnt, empty); end
      for (int i = 0; i < 6; i++) do_cycle(0, 0, 1, 1, DW'(i), 0, '0);
      checks++; if (drop_cnt !== 16'd6 || s_drop_cnt !== 2'd3) begin errors++; $display("FAIL drop_sat got %0d/%0d want 6/3", drop_cnt, s_drop_cnt); end
   endtask

   task automatic test_random();
      logic r, c, f, p, re;
      for (int n = 0; n < 400; n++) begin
         r  = ($urandom_range(0, 99) == 0);
         c  = ($urandom_range(0, 29) == 0);
         f  = ($urandom_range(0, 3) == 0);
         p  = ($urandom_range(0, 1) == 1);
         re = ($urandom_range(0, 1) == 1);
         do_cycle(r, c, f, p, $urandom, re, IDX_W'($urandom_range(0, 15)));
         checks++; if (count !== CNT_W'(mq.size())) begin errors++; $display("FAIL rnd_count n=%0d got %0d want %0d", n, count, mq.size()); end
         checks++; if (sum !== model_sum()) begin errors++; $display("FAIL rnd_sum n=%0d got %0d want %0d", n, sum, model_sum()); end
         checks++; if ({full, empty} !== {mq.size() == DEPTH, mq.size() == 0}) begin errors++; $display("FAIL rnd_flags n=%0d got %b%b size=%0d", n, full, empty, mq.size()); end
         checks++; if (drop_cnt !== 16'(m_drop) || s_drop_cnt !== model_drop_sat()) begin errors++; $display("FAIL rnd_drop n=%0d got %0d/%0d want %0d/%0d", n, drop_cnt, s_drop_cnt, m_drop, model_drop_sat()); end
         checks++; if (rd_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid n=%0d got %b want %b", n, rd_valid, exp_valid); end
         if (exp_valid) begin
            checks++; if (rd_data !== exp_data || rd_err !== exp_err) begin errors++; $display("FAIL rnd_read n=%0d got d=%h e=%b want %h %b", n, rd_data, rd_err, exp_data, exp_err); end
            checks++; if (s_rd_data !== exp_data || s_rd_err !== exp_err) begin errors++; $display("FAIL rnd_read_sat n=%0d got d=%h e=%b want %h %b", n, s_rd_data, s_rd_err, exp_data, exp_err); end
         end
         checks++; if ({s_count, s_sum, s_full, s_empty, s_rd_valid} !== {CNT_W'(mq.size()), model_sum(), mq.size() == DEPTH, mq.size() == 0, exp_valid}) begin
            errors++; $display("FAIL rnd_sat_state n=%0d got count=%0d sum=%0d", n, s_count, s_sum);
         end
      end
   endtask

   initial begin
      reset = 1; clear = 0; freeze = 0; push_en = 0; push_data = '0; rd_en = 0; rd_idx = '0;
      m_drop = 0; exp_valid = 0; exp_err = 0; exp_data = '0;
      @(negedge clk);
      test_reset();
      test_basic();
      test_fill();
      test_freeze();
      test_clear();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
